branch_run_controller: RTL and testbench
========================================

// Module: branch_run_controller
// PURPOSE
//  Run-control and branch-decode controller for the program sequencer.
//  - Decodes the fetched instruction into the sequencer's jump controls.
//  - Owns the ALU zero flag used by conditional jumps.
//  - Holds the sequencer in reset until started, and returns it to reset on HALT.
//  - Keeps saturating counters of instructions executed and branches taken.
//  Sits between the synchronous program ROM output and the sequencer control inputs.
// PARAMETERS
//  CNT_W        16      width of instr_cnt and taken_cnt
//  JMP_OP       4'hE    ir[7:4] value for an unconditional jump
//  JMP_NZ_OP    4'hF    ir[7:4] value for jump-if-not-zero
//  HALT_OPCODE  8'hC7   full-byte halt instruction; the ALU decoder treats it as a NOP
// PORTS
//  clk            in   1      system clock; all state changes on rising edge
//  sync_reset     in   1      synchronous, active-high reset
//  start          in   1      1-cycle pulse: begin execution from address 0
//  ir             in   8      instruction at current pc (sync ROM output)
//  alu_z          in   1      ALU result-is-zero, valid when z_we=1
//  z_we           in   1      load alu_z into zero flag
//  ps_sync_reset  out  1      drives sequencer sync_reset
//  jmp            out  1      drives sequencer jmp
//  jmp_nz         out  1      drives sequencer jmp_nz
//  dont_jmp       out  1      drives sequencer dont_jmp (= zero flag)
//  jmp_addr       out  4      drives sequencer jmp_addr (= ir[3:0])
//  running        out  1      1 in RUN state
//  halted         out  1      1 in HALTED state
//  instr_cnt      out  CNT_W  RUN cycles since last start; saturates
//  taken_cnt      out  CNT_W  taken jumps since last start; saturates
// BEHAVIOUR
//  FSM states: IDLE, RUN, HALTED. Reset state is IDLE.
//  - IDLE   -> RUN on start.
//  - RUN    -> HALTED when ir == HALT_OPCODE; the HALT cycle itself counts in instr_cnt.
//  - HALTED -> RUN on start.
//  - start in RUN is ignored.
//  ps_sync_reset = 1 in IDLE and HALTED, 0 in RUN (Moore, registered state).
//   Because the sequencer is held at pm_addr=0, ir=ROM[0] is valid in the 1st RUN cycle.
//  Decode is combinational, from ir, in RUN only; all zero outside RUN:
//   jmp    = (ir[7:4]==JMP_OP)
//   jmp_nz = (ir[7:4]==JMP_NZ_OP)
//   jmp_addr = ir[3:0] in every state.
//  Zero flag z_reg:
//   - reset 0; z_reg <= alu_z when z_we (any state).
//   - dont_jmp = z_reg (registered), so z_we together with jmp_nz in the same
//     cycle uses the OLD flag; the new value applies from the next cycle.
//  Counters:
//   - both cleared by reset and on every accepted start;
//   - instr_cnt +1 each RUN cycle;
//   - taken_cnt +1 in RUN when jmp | (jmp_nz & ~dont_jmp);
//   - both saturate at all-ones, no wrap.
//  start and HALT opcode in the same cycle: state is RUN, so start is ignored; -> HALTED.
//  sync_reset has priority over everything (mid-RUN included): -> IDLE next edge,
//   counters=0, z_reg=0, ps_sync_reset=1.
//  Reset values: ps_sync_reset=1, jmp=jmp_nz=dont_jmp=0, running=halted=0, cnts=0.
//   jmp_addr follows ir.
//  Latency: decode 0 cycles; state/flag/counter updates visible 1 cycle after the edge.
// STRUCTURE
//  Shared package: opcode constants (JMP_OP, JMP_NZ_OP, HALT_OPCODE) and the
//   FSM state encoding; the ALU decoder uses the same opcode constants.
//  One sub-module: sat_counter (parameter W; ports clr, inc, q), instanced for each counter.
//  FSM, zero flag and decode stay in this module.
// TESTING
//  1 reset, then start at cycle 3 -> ps_sync_reset 1->0 at cycle 4; running=1; instr_cnt counts 1,2,3..
//  2 RUN, ir=8'hE5 -> jmp=1, jmp_addr=4'h5, taken_cnt +1; seq pm_addr=8'h50.
//  3 z_we=1 alu_z=1, next cycle ir=8'hF3 -> jmp_nz=1, dont_jmp=1, taken_cnt unchanged.
//     Same cycle z_we=1 alu_z=1 with ir=8'hF3 and old z=0 -> jump taken.
//  4 ir=8'hC7 in RUN -> halted=1, ps_sync_reset=1 next cycle; start -> RUN, counters=0.
//  5 CNT_W=4, 20 taken jumps -> taken_cnt holds 4'hF, no wrap.
//  6 sync_reset mid-RUN with jmp active -> IDLE next cycle, all outputs at reset values.

Source files
------------

// File: rtl/branch_run_controller_pkg.sv
// Shared opcode constants and FSM state encoding for the run/branch controller
// and the ALU decoder.
package branch_run_controller_pkg;

  localparam logic [3:0] JMP_OP      = 4'hE;
  localparam logic [3:0] JMP_NZ_OP   = 4'hF;
  localparam logic [7:0] HALT_OPCODE = 8'hC7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } run_state_t;

endpackage

// File: rtl/branch_run_controller_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr)
      q_d = '0;
    else if (inc && (q_q != {W{1'b1}}))
      q_d = q_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/branch_run_controller.sv
// Run-control FSM, zero flag and branch decode between program ROM and sequencer.
//
// state     | meaning
// ST_IDLE   | sequencer held in reset, waiting for start
// ST_RUN    | sequencer executing, decode and counters active
// ST_HALTED | HALT seen, sequencer held in reset, counters frozen
module branch_run_controller
  import branch_run_controller_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             sync_reset,
  input  logic             start,
  input  logic [7:0]       ir,
  input  logic             alu_z,
  input  logic             z_we,
  output logic             ps_sync_reset,
  output logic             jmp,
  output logic             jmp_nz,
  output logic             dont_jmp,
  output logic [3:0]       jmp_addr,
  output logic             running,
  output logic             halted,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  run_state_t state_q;
  logic       ps_sync_reset_q;
  logic       running_q;
  logic       halted_q;
  logic       z_q, z_d;
  logic       start_accept;
  logic       taken;

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      state_q         <= ST_IDLE;
      ps_sync_reset_q <= 1'b1;
      running_q       <= 1'b0;
      halted_q        <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_HALTED: begin
          if (start) begin
            state_q         <= ST_RUN;
            ps_sync_reset_q <= 1'b0;
            running_q       <= 1'b1;
            halted_q        <= 1'b0;
          end
        end
        ST_RUN: begin
          if (ir == HALT_OPCODE) begin
            state_q         <= ST_HALTED;
            ps_sync_reset_q <= 1'b1;
            running_q       <= 1'b0;
            halted_q        <= 1'b1;
          end
        end
        default: begin
          state_q         <= ST_IDLE;
          ps_sync_reset_q <= 1'b1;
          running_q       <= 1'b0;
          halted_q        <= 1'b0;
        end
      endcase
    end
  end

  // Flag loads in any state; consumers see the old value during the load cycle.
  always_comb begin
    z_d = z_q;
    if (sync_reset)
      z_d = 1'b0;
    else if (z_we)
      z_d = alu_z;
  end

  always_ff @(posedge clk) begin
    z_q <= z_d;
  end

  assign jmp      = running_q && (ir[7:4] == JMP_OP);
  assign jmp_nz   = running_q && (ir[7:4] == JMP_NZ_OP);
  assign jmp_addr = ir[3:0];
  assign dont_jmp = z_q;

  assign start_accept = start && (state_q != ST_RUN);
  assign taken        = jmp || (jmp_nz && !z_q);

  sat_counter #(.W(CNT_W)) u_instr_cnt (
    .clk (clk),
    .clr (sync_reset || start_accept),
    .inc (running_q),
    .q   (instr_cnt)
  );

  sat_counter #(.W(CNT_W)) u_taken_cnt (
    .clk (clk),
    .clr (sync_reset || start_accept),
    .inc (taken),
    .q   (taken_cnt)
  );

  assign ps_sync_reset = ps_sync_reset_q;
  assign running       = running_q;
  assign halted        = halted_q;

endmodule

// File: tb/tb_branch_run_controller.sv
// Directed bench: table of per-cycle vectors plus hand sequences for reset and saturation.
module tb_branch_run_controller;

  logic        clk = 1'b0;
  logic        sync_reset;
  logic        start;
  logic [7:0]  ir;
  logic        alu_z;
  logic        z_we;

  logic        ps_sync_reset, jmp, jmp_nz, dont_jmp, running, halted;
  logic [3:0]  jmp_addr;
  logic [15:0] instr_cnt, taken_cnt;

  logic        ps2, jmp2, jnz2, dj2, run2, halt2;
  logic [3:0]  addr2;
  logic [3:0]  ic2, tc2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  branch_run_controller #(.CNT_W(16)) dut (
    .clk(clk), .sync_reset(sync_reset), .start(start), .ir(ir), .alu_z(alu_z), .z_we(z_we),
    .ps_sync_reset(ps_sync_reset), .jmp(jmp), .jmp_nz(jmp_nz), .dont_jmp(dont_jmp),
    .jmp_addr(jmp_addr), .running(running), .halted(halted),
    .instr_cnt(instr_cnt), .taken_cnt(taken_cnt)
  );

  branch_run_controller #(.CNT_W(4)) dut4 (
    .clk(clk), .sync_reset(sync_reset), .start(start), .ir(ir), .alu_z(alu_z), .z_we(z_we),
    .ps_sync_reset(ps2), .jmp(jmp2), .jmp_nz(jnz2), .dont_jmp(dj2),
    .jmp_addr(addr2), .running(run2), .halted(halt2),
    .instr_cnt(ic2), .taken_cnt(tc2)
  );

  typedef struct {
    logic       start;
    logic       z_we;
    logic       alu_z;
    logic [7:0] ir;
    logic       ps;
    logic       jmp;
    logic       jnz;
    logic       dj;
    logic       run;
    logic       halt;
    logic [3:0] addr;
    int         ic;
    int         tc;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input int row, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    //          start we  z   ir     ps jmp jnz dj run hlt addr ic tc
    vecs[0]  = '{0, 0, 0, 8'h00, 1, 0, 0, 0, 0, 0, 4'h0, 0, 0};
    vecs[1]  = '{0, 0, 0, 8'hE5, 1, 0, 0, 0, 0, 0, 4'h5, 0, 0};
    vecs[2]  = '{1, 0, 0, 8'h00, 1, 0, 0, 0, 0, 0, 4'h0, 0, 0};
    vecs[3]  = '{0, 0, 0, 8'h00, 0, 0, 0, 0, 1, 0, 4'h0, 0, 0};
    vecs[4]  = '{0, 0, 0, 8'hE5, 0, 1, 0, 0, 1, 0, 4'h5, 1, 0};
    vecs[5]  = '{0, 1, 1, 8'h00, 0, 0, 0, 0, 1, 0, 4'h0, 2, 1};
    vecs[6]  = '{0, 0, 0, 8'hF3, 0, 0, 1, 1, 1, 0, 4'h3, 3, 1};
    vecs[7]  = '{0, 1, 0, 8'h00, 0, 0, 0, 1, 1, 0, 4'h0, 4, 1};
    vecs[8]  = '{0, 1, 1, 8'hF3, 0, 0, 1, 0, 1, 0, 4'h3, 5, 1};
    vecs[9]  = '{0, 0, 0, 8'h00, 0, 0, 0, 1, 1, 0, 4'h0, 6, 2};
    vecs[10] = '{1, 0, 0, 8'h00, 0, 0, 0, 1, 1, 0, 4'h0, 7, 2};
    vecs[11] = '{1, 0, 0, 8'hC7, 0, 0, 0, 1, 1, 0, 4'h7, 8, 2};
    vecs[12] = '{0, 0, 0, 8'hF3, 1, 0, 0, 1, 0, 1, 4'h3, 9, 2};
    vecs[13] = '{0, 1, 0, 8'h00, 1, 0, 0, 1, 0, 1, 4'h0, 9, 2};
    vecs[14] = '{1, 0, 0, 8'h00, 1, 0, 0, 0, 0, 1, 4'h0, 9, 2};
    vecs[15] = '{0, 0, 0, 8'hE1, 0, 1, 0, 0, 1, 0, 4'h1, 0, 0};
    vecs[16] = '{0, 0, 0, 8'h00, 0, 0, 0, 0, 1, 0, 4'h0, 1, 1};

    sync_reset = 1'b1; start = 1'b0; ir = 8'h00; alu_z = 1'b0; z_we = 1'b0;
    next_cycle();
    next_cycle();
    sync_reset = 1'b0;

    for (int i = 0; i < 17; i++) begin
      start = vecs[i].start; z_we = vecs[i].z_we; alu_z = vecs[i].alu_z; ir = vecs[i].ir;
      #2;
      check("ps_sync_reset", i, ps_sync_reset, vecs[i].ps);
      check("jmp",           i, jmp,           vecs[i].jmp);
      check("jmp_nz",        i, jmp_nz,        vecs[i].jnz);
      check("dont_jmp",      i, dont_jmp,      vecs[i].dj);
      check("running",       i, running,       vecs[i].run);
      check("halted",        i, halted,        vecs[i].halt);
      check("jmp_addr",      i, jmp_addr,      vecs[i].addr);
      check("instr_cnt",     i, instr_cnt,     vecs[i].ic);
      check("taken_cnt",     i, taken_cnt,     vecs[i].tc);
      next_cycle();
    end

    // Set the flag, then reset mid-RUN while a jump is being decoded.
    start = 1'b0; z_we = 1'b1; alu_z = 1'b1; ir = 8'h00;
    next_cycle();
    z_we = 1'b0; ir = 8'hEA; sync_reset = 1'b1;
    #2;
    check("rst_pre_jmp",      100, jmp,      1);
    check("rst_pre_dont_jmp", 100, dont_jmp, 1);
    next_cycle();
    sync_reset = 1'b0;
    #2;
    check("rst_ps_sync_reset", 101, ps_sync_reset, 1);
    check("rst_jmp",           101, jmp,           0);
    check("rst_jmp_nz",        101, jmp_nz,        0);
    check("rst_dont_jmp",      101, dont_jmp,      0);
    check("rst_running",       101, running,       0);
    check("rst_halted",        101, halted,        0);
    check("rst_jmp_addr",      101, jmp_addr,      4'hA);
    check("rst_instr_cnt",     101, instr_cnt,     0);
    check("rst_taken_cnt",     101, taken_cnt,     0);
    next_cycle();

    // Saturation: 20 back-to-back taken jumps on both counter widths.
    start = 1'b1; ir = 8'h00;
    next_cycle();
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      ir = 8'hE0;
      #2;
      check("sat16_taken", 200 + i, taken_cnt, i);
      check("sat4_taken",  200 + i, tc2, (i > 15) ? 15 : i);
      check("sat4_instr",  200 + i, ic2, (i > 15) ? 15 : i);
      next_cycle();
    end
    ir = 8'h00;
    #2;
    check("sat4_taken_hold", 300, tc2, 4'hF);
    check("sat4_running",    300, run2, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
